// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
// A start in IDLE or DONE latches the operands; a zero divisor bypasses the
// iteration and returns an all-ones quotient with div_by_zero set. Results are
// registered and held from one done pulse to the next.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;

    // latched operands and iteration state
    logic [DW-1:0] dvd_r;      // dividend, shifted left so the next bit is always at the MSB
    logic [VW-1:0] dvs_r;
    logic [VW-1:0] rem_r;      // partial remainder, always < divisor so VW bits suffice
    logic [DW-1:0] quo_r;
    logic [CW-1:0] cnt_r;

    // registered outputs
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          dbz_r;

    // one restoring step
    logic [VW:0]   trial_s;    // VW+1-bit partial remainder after shifting in the next bit
    logic [VW-1:0] rem_next_s;
    logic          qbit_s;
    logic [DW-1:0] quo_next_s;

    // FSM control strobes
    logic          load_s;
    logic          zero_s;
    logic          step_s;
    logic          finish_s;

    // restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial_s    = {rem_r, dvd_r[DW-1]};
        rem_next_s = trial_s[VW-1:0];
        qbit_s     = 1'b0;
        if (trial_s >= {1'b0, dvs_r}) begin
            // the difference is below the divisor, so its top bit is always zero
            rem_next_s = trial_s[VW-1:0] - dvs_r;
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = trial_s[VW-1:0];
            qbit_s     = 1'b0;
        end
        quo_next_s = {quo_r[DW-2:0], qbit_s};
    end

    // next-state logic and datapath strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        zero_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s = 1'b1;
                    if (divisor == {VW{1'b0}}) begin
                        zero_s       = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = CALC;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s     = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // state register with busy/done registered alongside so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == CALC);
            done_r  <= (next_state_s == DONE);
        end
    end

    // operand latch and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r <= {DW{1'b0}};
            dvs_r <= {VW{1'b0}};
            rem_r <= {VW{1'b0}};
            quo_r <= {DW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            rem_r <= {VW{1'b0}};
            quo_r <= {DW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (step_s) begin
            dvd_r <= {dvd_r[DW-2:0], 1'b0};
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // result registers: written only on entry to DONE so they hold between operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else if (zero_s) begin
            quotient_r  <= {DW{1'b1}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b1;
        end else if (finish_s) begin
            quotient_r  <= quo_next_s;
            remainder_r <= rem_next_s;
            dbz_r       <= 1'b0;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scenario tasks plus a long randomized back-to-back run,
// checked against an integer-arithmetic reference model.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int vectors;
    int miscompares;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // integer reference: results and timing derived from the arithmetic definition
    function automatic void model(input int dd, input int dv, output int q, output int r,
                                  output int dz, output int lat, output int bc);
        if (dv == 0) begin
            q = (1 << DW) - 1; r = 0; dz = 1; lat = 1; bc = 0;
        end else begin
            q = dd / dv; r = dd % dv; dz = 0; lat = DW + 1; bc = DW;
        end
    endfunction

    // issue one start now and wait (bounded) for done; called #1 after an edge
    task automatic do_op(input int dd, input int dv, output int q, output int r, output int dz,
                         output int lat, output int bc, output int ovl, output bit tmo);
        start = 1'b1; dividend = DW'(dd); divisor = VW'(dv);
        q = 0; r = 0; dz = 0; lat = 0; bc = 0; ovl = 0; tmo = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
            if (busy) bc++;
            if (busy && done) ovl++;
            if (done) begin
                lat = c; q = int'(quotient); r = int'(remainder); dz = int'(div_by_zero);
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        bit seen;
        rst_n = 1'b0; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_accept: got busy=%0b expected 1", busy);
        end
        seen = 1'b0; c = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; c = i; break; end
        end
        vectors++;
        if (!seen || c != 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
            miscompares++;
            $display("FAIL first_result: got seen=%0b lat=%0d q=%0d r=%0d expected lat=9 q=28 r=4",
                     seen, c, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int q, r, dz, lat, bc, ovl;
        bit tmo;
        do_op(200, 7, q, r, dz, lat, bc, ovl, tmo);
        vectors++;
        if (tmo || q != 28 || r != 4 || dz != 0 || lat != 9 || bc != 8 || ovl != 0) begin
            miscompares++;
            $display("FAIL basic_200_7: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d busy=%0d ovl=%0d expected q=28 r=4 dz=0 lat=9 busy=8 ovl=0",
                     tmo, q, r, dz, lat, bc, ovl);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
            miscompares++;
            $display("FAIL basic_hold: got done=%0b busy=%0b q=%0d r=%0d expected done=0 busy=0 q=28 r=4",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_extremes();
        int dds[4] = '{255, 255, 0, 5};
        int dvs[4] = '{15, 1, 9, 9};
        int eq[4]  = '{17, 255, 0, 0};
        int er[4]  = '{0, 0, 0, 5};
        int q, r, dz, lat, bc, ovl;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            do_op(dds[i], dvs[i], q, r, dz, lat, bc, ovl, tmo);
            vectors++;
            if (tmo || q != eq[i] || r != er[i] || dz != 0 || lat != 9 || bc != 8) begin
                miscompares++;
                $display("FAIL extreme_%0d_%0d: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d busy=%0d expected q=%0d r=%0d dz=0 lat=9 busy=8",
                         dds[i], dvs[i], tmo, q, r, dz, lat, bc, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int q, r, dz, lat, bc, ovl;
        bit tmo;
        do_op(100, 0, q, r, dz, lat, bc, ovl, tmo);
        vectors++;
        if (tmo || q != 255 || r != 0 || dz != 1 || lat != 1 || bc != 0) begin
            miscompares++;
            $display("FAIL divzero_100_0: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d busy=%0d expected q=255 r=0 dz=1 lat=1 busy=0",
                     tmo, q, r, dz, lat, bc);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL divzero_after: got done=%0b busy=%0b dz=%0b expected done=0 busy=0 dz=1",
                     done, busy, div_by_zero);
        end
        do_op(9, 3, q, r, dz, lat, bc, ovl, tmo);
        vectors++;
        if (tmo || q != 3 || r != 0 || dz != 0 || lat != 9) begin
            miscompares++;
            $display("FAIL divzero_next_9_3: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d expected q=3 r=0 dz=0 lat=9",
                     tmo, q, r, dz, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int c;
        bit seen;
        bit busy1;
        // start arriving mid-operation must be ignored
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        seen = 1'b0; c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; c = i; break; end
            if (i == 4) begin
                start = 1'b1; dividend = 8'd50; divisor = 4'd5;
            end else begin
                start = 1'b0; dividend = 8'd17; divisor = 4'd2;
            end
        end
        vectors++;
        if (!seen || c != 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
            miscompares++;
            $display("FAIL ignore_mid_start: got seen=%0b lat=%0d q=%0d r=%0d expected lat=9 q=28 r=4",
                     seen, c, quotient, remainder);
        end
        // start in the done cycle is accepted
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        seen = 1'b0; c = 0; busy1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 1) busy1 = busy;
            if (done) begin seen = 1'b1; c = i; break; end
        end
        vectors++;
        if (!seen || !busy1 || c != 9 || quotient !== 8'd10 || remainder !== 4'd0) begin
            miscompares++;
            $display("FAIL done_cycle_start: got seen=%0b busy1=%0b lat=%0d q=%0d r=%0d expected busy1=1 lat=9 q=10 r=0",
                     seen, busy1, c, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int q, r, dz, lat, bc, ovl;
        bit tmo;
        int bad;
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid_calc: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy || quotient != 8'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_discard: got %0d cycles with activity expected 0", bad);
        end
        do_op(64, 8, q, r, dz, lat, bc, ovl, tmo);
        vectors++;
        if (tmo || q != 8 || r != 0 || dz != 0 || lat != 9) begin
            miscompares++;
            $display("FAIL after_reset_64_8: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d expected q=8 r=0 dz=0 lat=9",
                     tmo, q, r, dz, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int dd, dv;
        int q, r, dz, lat, bc, ovl;
        int eq, er, edz, elat, ebc;
        bit tmo;
        // each new start is issued in the done cycle of the previous operation
        for (int n = 0; n < 10000; n++) begin
            dd = int'($urandom_range(0, (1 << DW) - 1));
            dv = int'($urandom_range(0, (1 << VW) - 1));
            model(dd, dv, eq, er, edz, elat, ebc);
            do_op(dd, dv, q, r, dz, lat, bc, ovl, tmo);
            vectors++;
            if (tmo || q != eq || r != er || dz != edz || lat != elat || bc != ebc || ovl != 0) begin
                miscompares++;
                $display("FAIL random_%0d_%0d: got tmo=%0b q=%0d r=%0d dz=%0d lat=%0d busy=%0d ovl=%0d expected q=%0d r=%0d dz=%0d lat=%0d busy=%0d ovl=0",
                         dd, dv, tmo, q, r, dz, lat, bc, ovl, eq, er, edz, elat, ebc);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        #1;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
